// File: rtl/ysyx_25070198_mem_arbiter_if.sv
// Request/response bundle shared by the IFU port, the LSU port and the memory slave port.
// The master modport issues requests and receives responses; the slave modport is the serving side.
interface ysyx_25070198_mem_arbiter_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_wen;
   logic [31:0] req_wdata;
   logic [3:0]  req_wmask;
   logic        resp_valid;
   logic [31:0] resp_data;

   modport master (
      output req_valid, req_addr, req_wen, req_wdata, req_wmask,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
      output req_ready, resp_valid, resp_data
   );
endinterface

// File: rtl/ysyx_25070198_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter, one transaction in flight, with response timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise LSU has fixed priority over IFU.
module ysyx_25070198_mem_arbiter #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic clk,
   input  logic rst,
   ysyx_25070198_mem_arbiter_if.slave  ifu,
   ysyx_25070198_mem_arbiter_if.slave  lsu,
   ysyx_25070198_mem_arbiter_if.master mem,
   output logic busy,
   output logic err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic        owner_lsu;
   logic [31:0] addr_q;
   logic        wen_q;
   logic [31:0] wdata_q;
   logic [3:0]  wmask_q;
   logic [31:0] data_q;
   logic        err_q;
   logic [15:0] cnt;
   logic        grant_lsu;
   logic        accept;
   logic        unused_ifu_fields;

   // The IFU only fetches, so its write-side fields never reach the slave.
   assign unused_ifu_fields = ^{ifu.req_wen, ifu.req_wdata, ifu.req_wmask};

`ifdef ARB_ROUND_ROBIN_EN
   logic last_lsu;

   assign grant_lsu = lsu.req_valid && (!ifu.req_valid || !last_lsu);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_lsu <= 1'b1;
      end else if (accept) begin
         last_lsu <= grant_lsu;
      end
   end
`else
   assign grant_lsu = lsu.req_valid;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      accept        = 1'b0;
      ifu.req_ready = 1'b0;
      lsu.req_ready = 1'b0;
      case (state)
         IDLE: begin
            ifu.req_ready = ifu.req_valid && !grant_lsu;
            lsu.req_ready = grant_lsu;
            accept        = ifu.req_valid || lsu.req_valid;
            if (accept) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (mem.req_ready) begin
               state_next = mem.resp_valid ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (mem.resp_valid || cnt == CNT_LAST) begin
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request fields are frozen at accept so the slave sees them stable for the whole REQ phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_lsu <= 1'b0;
         addr_q    <= 32'd0;
         wen_q     <= 1'b0;
         wdata_q   <= 32'd0;
         wmask_q   <= 4'd0;
         data_q    <= 32'd0;
         err_q     <= 1'b0;
         cnt       <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= 16'd0;
               if (accept) begin
                  owner_lsu <= grant_lsu;
                  addr_q    <= grant_lsu ? lsu.req_addr : ifu.req_addr;
                  wen_q     <= grant_lsu && lsu.req_wen;
                  wdata_q   <= grant_lsu ? lsu.req_wdata : 32'd0;
                  wmask_q   <= (grant_lsu && lsu.req_wen) ? lsu.req_wmask : 4'd0;
                  err_q     <= 1'b0;
               end
            end
            REQ: begin
               if (mem.req_ready && mem.resp_valid) begin
                  data_q <= wen_q ? 32'd0 : mem.resp_data;
               end
            end
            WAIT: begin
               cnt <= cnt + 16'd1;
               if (mem.resp_valid) begin
                  data_q <= wen_q ? 32'd0 : mem.resp_data;
               end else if (cnt == CNT_LAST) begin
                  data_q <= ERR_DATA;
                  err_q  <= 1'b1;
               end
            end
            RESP: begin
               cnt   <= 16'd0;
               err_q <= 1'b0;
            end
            default: cnt <= 16'd0;
         endcase
      end
   end

   assign mem.req_valid = (state == REQ);
   assign mem.req_addr  = addr_q;
   assign mem.req_wen   = wen_q;
   assign mem.req_wdata = wdata_q;
   assign mem.req_wmask = wmask_q;

   assign ifu.resp_valid = (state == RESP) && !owner_lsu;
   assign lsu.resp_valid = (state == RESP) && owner_lsu;
   assign ifu.resp_data  = ifu.resp_valid ? data_q : 32'd0;
   assign lsu.resp_data  = lsu.resp_valid ? data_q : 32'd0;

   assign busy = (state != IDLE);
   assign err  = (state == RESP) && err_q;

endmodule

// File: tb/tb_ysyx_25070198_mem_arbiter.sv
// Randomized self-checking bench for ysyx_25070198_mem_arbiter; expected timing and data come from
// transaction-level arithmetic (accept, ready delay, response offset, timeout) rather than a state machine.
module tb_ysyx_25070198_mem_arbiter;
   localparam int          TMO  = 15;
   localparam logic [31:0] ERRD = 32'hDEADBEEF;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   logic err;

   always #5 clk = ~clk;

   ysyx_25070198_mem_arbiter_if ifu_bus();
   ysyx_25070198_mem_arbiter_if lsu_bus();
   ysyx_25070198_mem_arbiter_if mem_bus();

   ysyx_25070198_mem_arbiter #(.TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
      .clk  (clk),
      .rst  (rst),
      .ifu  (ifu_bus.slave),
      .lsu  (lsu_bus.slave),
      .mem  (mem_bus.master),
      .busy (busy),
      .err  (err)
   );

   int checks = 0;
   int errors = 0;

   // Per-master request and slave behaviour; index 0 = IFU, 1 = LSU.
   logic [31:0] req_addr   [2];
   logic        req_wen    [2];
   logic [31:0] req_wdata  [2];
   logic [3:0]  req_wmask  [2];
   logic [31:0] slave_data [2];
   int          ready_dly  [2];
   int          resp_off   [2];
   bit          last_lsu;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int tie_winner();
`ifdef ARB_ROUND_ROBIN_EN
      return last_lsu ? 0 : 1;
`else
      return 1;
`endif
   endfunction

   task automatic clear_inputs();
      ifu_bus.req_valid  = 1'b0;
      ifu_bus.req_addr   = 32'd0;
      ifu_bus.req_wen    = 1'b0;
      ifu_bus.req_wdata  = 32'd0;
      ifu_bus.req_wmask  = 4'd0;
      lsu_bus.req_valid  = 1'b0;
      lsu_bus.req_addr   = 32'd0;
      lsu_bus.req_wen    = 1'b0;
      lsu_bus.req_wdata  = 32'd0;
      lsu_bus.req_wmask  = 4'd0;
      mem_bus.req_ready  = 1'b0;
      mem_bus.resp_valid = 1'b0;
      mem_bus.resp_data  = 32'd0;
   endtask

   task automatic check_quiet(input string tag);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_mem_valid"}, mem_bus.req_valid, 0);
      checkOutput({tag, "_ifu_resp"}, ifu_bus.resp_valid, 0);
      checkOutput({tag, "_lsu_resp"}, lsu_bus.resp_valid, 0);
      checkOutput({tag, "_err"}, err, 0);
   endtask

   // Entered at negedge+1 of the accept cycle; leaves at negedge+1 of the following idle cycle.
   task automatic serve_one(input int m);
      int          h;
      int          e;
      bit          exp_err;
      logic [31:0] exp_data;
      h        = 1 + ready_dly[m];
      exp_err  = resp_off[m] > TMO;
      e        = exp_err ? h + TMO + 1 : h + resp_off[m] + 1;
      exp_data = exp_err ? ERRD : (req_wen[m] ? 32'd0 : slave_data[m]);
      checkOutput("accept_ifu_ready", ifu_bus.req_ready, m == 0);
      checkOutput("accept_lsu_ready", lsu_bus.req_ready, m == 1);
      checkOutput("accept_busy", busy, 0);
      last_lsu = (m == 1);
      for (int c = 1; c <= e; c++) begin
         @(negedge clk);
         if (m == 0) ifu_bus.req_valid = 1'b0;
         else        lsu_bus.req_valid = 1'b0;
         mem_bus.req_ready  = (c == h) || (c > h && $urandom_range(1, 0) == 1);
         mem_bus.resp_valid = (c == h + resp_off[m]);
         mem_bus.resp_data  = mem_bus.resp_valid ? slave_data[m] : $urandom();
         #1;
         checkOutput("busy", busy, 1);
         checkOutput("mem_req_valid", mem_bus.req_valid, c <= h);
         if (c <= h) begin
            checkOutput("mem_req_addr", mem_bus.req_addr, req_addr[m]);
            checkOutput("mem_req_wen", mem_bus.req_wen, req_wen[m]);
            checkOutput("mem_req_wmask", mem_bus.req_wmask, req_wen[m] ? req_wmask[m] : 4'd0);
            if (req_wen[m]) checkOutput("mem_req_wdata", mem_bus.req_wdata, req_wdata[m]);
         end
         checkOutput("busy_ifu_ready", ifu_bus.req_ready, 0);
         checkOutput("busy_lsu_ready", lsu_bus.req_ready, 0);
         checkOutput("ifu_resp_valid", ifu_bus.resp_valid, c == e && m == 0);
         checkOutput("lsu_resp_valid", lsu_bus.resp_valid, c == e && m == 1);
         checkOutput("err", err, c == e && exp_err);
         if (c == e) begin
            if (m == 0) checkOutput("ifu_resp_data", ifu_bus.resp_data, exp_data);
            else        checkOutput("lsu_resp_data", lsu_bus.resp_data, exp_data);
         end
      end
      @(negedge clk);
      mem_bus.req_ready  = 1'b0;
      mem_bus.resp_valid = 1'b0;
      #1;
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_err", err, 0);
   endtask

   task automatic applyStimulus(input bit ifu_go, input bit lsu_go);
      int first;
      @(negedge clk);
      ifu_bus.req_valid = ifu_go;
      ifu_bus.req_addr  = req_addr[0];
      ifu_bus.req_wen   = 1'b1;
      ifu_bus.req_wdata = $urandom();
      ifu_bus.req_wmask = 4'hF;
      lsu_bus.req_valid = lsu_go;
      lsu_bus.req_addr  = req_addr[1];
      lsu_bus.req_wen   = req_wen[1];
      lsu_bus.req_wdata = req_wdata[1];
      lsu_bus.req_wmask = req_wmask[1];
      #1;
      if (ifu_go && lsu_go) first = tie_winner();
      else                  first = lsu_go ? 1 : 0;
      serve_one(first);
      if (ifu_go && lsu_go) serve_one(1 - first);
   endtask

   task automatic set_ifu(input logic [31:0] a, input int rd, input int ro, input logic [31:0] d);
      req_addr[0]   = a;
      req_wen[0]    = 1'b0;
      req_wdata[0]  = 32'd0;
      req_wmask[0]  = 4'd0;
      ready_dly[0]  = rd;
      resp_off[0]   = ro;
      slave_data[0] = d;
   endtask

   task automatic set_lsu(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] wm, input int rd, input int ro, input logic [31:0] d);
      req_addr[1]   = a;
      req_wen[1]    = w;
      req_wdata[1]  = wd;
      req_wmask[1]  = wm;
      ready_dly[1]  = rd;
      resp_off[1]   = ro;
      slave_data[1] = d;
   endtask

   function automatic int pick_offset();
      int opts [7];
      opts = '{0, 1, 2, 3, TMO, TMO + 1, 99};
      return opts[$urandom_range(6, 0)];
   endfunction

   // Abort a transaction in WAIT with reset, then make sure a late slave response goes nowhere.
   task automatic reset_midway();
      @(negedge clk);
      ifu_bus.req_valid = 1'b1;
      ifu_bus.req_addr  = 32'h8000_0040;
      @(negedge clk);
      ifu_bus.req_valid = 1'b0;
      mem_bus.req_ready = 1'b1;
      @(negedge clk);
      mem_bus.req_ready = 1'b0;
      #1;
      checkOutput("rst_pre_busy", busy, 1);
      rst = 1'b0;
      last_lsu = 1'b1;
      #1;
      check_quiet("rst_abort");
      checkOutput("rst_abort_addr", mem_bus.req_addr, 32'd0);
      checkOutput("rst_abort_ifu_data", ifu_bus.resp_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      mem_bus.resp_valid = 1'b1;
      mem_bus.resp_data  = 32'hCAFE_F00D;
      #1;
      check_quiet("rst_stale");
      @(negedge clk);
      mem_bus.resp_valid = 1'b0;
      #1;
      check_quiet("rst_after");
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      clear_inputs();
      last_lsu = 1'b1;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_quiet("reset");
      checkOutput("reset_ifu_ready", ifu_bus.req_ready, 0);
      checkOutput("reset_lsu_ready", lsu_bus.req_ready, 0);
      checkOutput("reset_mem_addr", mem_bus.req_addr, 32'd0);
      checkOutput("reset_mem_wmask", mem_bus.req_wmask, 4'd0);
      @(negedge clk);
      rst = 1'b1;

      set_ifu(32'h8000_0000, 0, 1, 32'h0010_0073);
      applyStimulus(1'b1, 1'b0);

      set_ifu(32'h8000_0000, 0, 1, 32'h1111_1111);
      set_lsu(32'h8000_0100, 1'b0, 32'd0, 4'd0, 0, 1, 32'h2222_2222);
      applyStimulus(1'b1, 1'b1);

      set_lsu(32'h8000_1000, 1'b1, 32'h1234_5678, 4'b0001, 0, 1, 32'h5555_5555);
      applyStimulus(1'b0, 1'b1);

      set_ifu(32'h8000_0004, 0, 99, 32'h7777_7777);
      applyStimulus(1'b1, 1'b0);

      set_ifu(32'h8000_0008, 0, TMO, 32'h3333_3333);
      applyStimulus(1'b1, 1'b0);

      reset_midway();
      set_ifu(32'h8000_0000, 0, 1, 32'h0010_0073);
      applyStimulus(1'b1, 1'b0);

      set_lsu(32'h8000_2000, 1'b0, 32'd0, 4'hA, 5, 0, 32'h4444_4444);
      applyStimulus(1'b0, 1'b1);

      for (int i = 0; i < 60; i++) begin
         int sel;
         sel = $urandom_range(2, 0);
         set_ifu({$urandom_range(1, 0) == 1 ? 4'h8 : 4'h3, $urandom_range(28'hFFFFFFF, 0)},
                 $urandom_range(5, 0), pick_offset(), $urandom());
         set_lsu($urandom(), 1'($urandom_range(1, 0)), $urandom(), 4'($urandom_range(15, 0)),
                 $urandom_range(5, 0), pick_offset(), $urandom());
         applyStimulus(sel != 1, sel != 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
